vsm_in_fifo_port: RTL and testbench
===================================

VSM_IN_FIFO_PORT -- requirements
Module: vsm_in_fifo_port

Interface
REQ-001 Parameter WIDTH, default 4: data word width in bits, at least 1.
REQ-002 Parameter DEPTH, default 4: FIFO entries, a power of two, at least 2.
REQ-003 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 ResetN  input  1  asynchronous, active-low reset.
REQ-005 DataIn  input  WIDTH  producer data word.
REQ-006 LoadIn  input  1  producer write strobe; one word per cycle while high.
REQ-007 ReadEn  input  1  CPU read strobe; each high cycle requests one pop.
REQ-008 ClearIn  input  1  synchronous flush.
REQ-009 BusOut  output  WIDTH  registered read data.
REQ-010 BusOe  output  1  bus drive enable; the top level maps it to the tristate buffer enable.
REQ-011 FullOut  output  1  high when the FIFO holds DEPTH words.
REQ-012 EmptyOut  output  1  high when the FIFO holds 0 words.
REQ-013 CountOut  output  clog2(DEPTH)+1  current occupancy.
REQ-014 OverflowOut  output  1  sticky flag: a producer write was dropped.
REQ-015 UnderflowOut  output  1  sticky flag: a read hit an empty FIFO.

Function
REQ-016 A push SHALL occur when LoadIn=1 and either FullOut=0 or a pop occurs in the same cycle.
- The pushed word is written at the write pointer.
REQ-017 A pop SHALL occur when ReadEn=1 and EmptyOut=0.
- The word already in the FIFO when the cycle starts is the one popped.
- A word pushed in the same cycle is never the one popped.
REQ-018 On a pop, the following cycle SHALL show BusOe=1 and BusOut=popped word, for exactly one cycle.
- Read latency is 1 cycle.
REQ-019 BusOe SHALL be 0 in every cycle not covered by REQ-018, and BusOut SHALL be all-zero whenever BusOe=0.
REQ-020 Each pointer SHALL wrap from DEPTH-1 to 0.
REQ-021 CountOut SHALL change as follows in the cycle after an access:
- +1 on a push only.
- -1 on a pop only.
- Unchanged on a simultaneous push and pop, or on neither.
REQ-022 FullOut and EmptyOut SHALL be registered and SHALL always be consistent with CountOut (Count=DEPTH and Count=0 respectively).
REQ-023 LoadIn=1 while full with no pop SHALL drop the word, leave the FIFO unchanged, and set OverflowOut from the next cycle.
REQ-024 ReadEn=1 while empty SHALL not pop, SHALL keep BusOe=0 next cycle, and SHALL set UnderflowOut from the next cycle.
- A push in that same cycle is still accepted.
REQ-025 OverflowOut and UnderflowOut SHALL remain set until ClearIn or reset.
REQ-026 ClearIn=1 SHALL, in the next cycle:
- Zero the pointers and CountOut, and set EmptyOut=1 and FullOut=0.
- Clear OverflowOut and UnderflowOut.
- Force BusOe=0.
REQ-027 ClearIn SHALL override any push or pop in the same cycle.
REQ-028 FIFO storage contents SHALL not need reset; no stale word is ever driven onto the bus.

Reset
REQ-029 While ResetN=0, the block SHALL immediately hold:
- BusOe=0 and BusOut=0.
- CountOut=0, EmptyOut=1, FullOut=0.
- OverflowOut=0 and UnderflowOut=0.
- Pointers at 0.
REQ-030 Reset asserted mid-operation SHALL discard all queued words.
REQ-031 The first push or pop SHALL be honoured on the first rising edge after ResetN deasserts.

Structure
REQ-032 Package vsm_pkg SHALL hold:
- VSM_DATA_W (4) and VSM_IN_DEPTH (4), used as the parameter defaults.
- A clog2-based count-width helper.
REQ-033 Storage SHALL sit in one sub-module, vsm_fifo_mem.
- It is a DEPTH x WIDTH register array with synchronous write and asynchronous read.
- Pointer, count, flag and bus-drive logic SHALL stay in vsm_in_fifo_port.

Verification
REQ-034 Reset, then push 0x1, 0x2, 0x3 (one per cycle), then ReadEn for 3 cycles:
- BusOe=1 with BusOut=0x1, 0x2, 0x3 on consecutive cycles, each one cycle after its ReadEn.
- Count ends at 0 and EmptyOut=1.
REQ-035 Push 5 words, 0x1 through 0x5, with DEPTH=4:
- FullOut=1 after the 4th push; OverflowOut=1 after the 5th.
- Subsequent reads return 0x1 to 0x4 only.
REQ-036 ReadEn on an empty FIFO -> BusOe stays 0, BusOut=0, UnderflowOut=1; a following ClearIn clears the flag.
REQ-037 Full FIFO with LoadIn=1 and ReadEn=1 in the same cycle -> oldest word is driven next cycle, the new word is stored, Count stays 4, no overflow.
REQ-038 Wrap-around: 10 interleaved push/pop pairs with data 0xA, 0xB, ... -> output order matches input order.
REQ-039 ResetN pulsed low with 3 words queued -> outputs reset immediately, the queued words are never read back, EmptyOut=1 after release.

Source files
------------

// File: rtl/vsm_pkg.sv
// Shared constants and helpers for the VSM input FIFO port.
package vsm_pkg;

  localparam int VSM_DATA_W   = 4;
  localparam int VSM_IN_DEPTH = 4;

  // Occupancy must reach DEPTH itself, hence one bit more than the pointer.
  function automatic int vsm_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vsm_in_fifo_port_if.sv
// Producer/CPU-side signal bundle of the VSM input FIFO port.
interface vsm_in_fifo_port_if
  import vsm_pkg::*;
#(
  parameter int WIDTH = VSM_DATA_W,
  parameter int DEPTH = VSM_IN_DEPTH
);

  localparam int CW = vsm_cnt_w(DEPTH);

  logic [WIDTH-1:0] DataIn;
  logic             LoadIn;
  logic             ReadEn;
  logic             ClearIn;
  logic [WIDTH-1:0] BusOut;
  logic             BusOe;
  logic             FullOut;
  logic             EmptyOut;
  logic [CW-1:0]    CountOut;
  logic             OverflowOut;
  logic             UnderflowOut;

  modport master (
    output DataIn, LoadIn, ReadEn, ClearIn,
    input  BusOut, BusOe, FullOut, EmptyOut, CountOut, OverflowOut, UnderflowOut
  );

  modport slave (
    input  DataIn, LoadIn, ReadEn, ClearIn,
    output BusOut, BusOe, FullOut, EmptyOut, CountOut, OverflowOut, UnderflowOut
  );

endinterface

// File: rtl/vsm_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module vsm_fifo_mem
  import vsm_pkg::*;
#(
  parameter int WIDTH = VSM_DATA_W,
  parameter int DEPTH = VSM_IN_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; the bus register only ever loads a word on a
  // valid pop, so an unwritten entry can never reach the outputs.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/vsm_in_fifo_port.sv
// Input FIFO port: producer pushes, CPU pops onto a registered, gated bus.
module vsm_in_fifo_port
  import vsm_pkg::*;
#(
  parameter int WIDTH = VSM_DATA_W,
  parameter int DEPTH = VSM_IN_DEPTH
) (
  input  logic               Clk,
  input  logic               ResetN,
  vsm_in_fifo_port_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = vsm_cnt_w(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             oe_q, oe_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic [WIDTH-1:0] rd_data;
  logic             push, pop, wr_en;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop   = bus.ReadEn && !empty_q;
  assign push  = bus.LoadIn && (!full_q || pop);
  assign wr_en = push && !bus.ClearIn;

  vsm_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk       (Clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.DataIn),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  // NOTE: every next-state signal gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    oe_d     = 1'b0;
    bus_d    = '0;
    if (bus.ClearIn) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        oe_d     = 1'b1;
        bus_d    = rd_data;
      end
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (bus.LoadIn && !push)    ovf_d = 1'b1;
      if (bus.ReadEn && empty_q)  udf_d = 1'b1;
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // NOTE: state registers use non-blocking assignments so all update together.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      oe_q     <= 1'b0;
      bus_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      oe_q     <= oe_d;
      bus_q    <= bus_d;
    end
  end

  assign bus.BusOut       = bus_q;
  assign bus.BusOe        = oe_q;
  assign bus.FullOut      = full_q;
  assign bus.EmptyOut     = empty_q;
  assign bus.CountOut     = count_q;
  assign bus.OverflowOut  = ovf_q;
  assign bus.UnderflowOut = udf_q;

endmodule

// File: tb/tb_vsm_in_fifo_port.sv
// Self-checking bench for vsm_in_fifo_port against a queue-based reference model.
module tb_vsm_in_fifo_port;
  import vsm_pkg::*;

  localparam int WIDTH = VSM_DATA_W;
  localparam int DEPTH = VSM_IN_DEPTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vsm_in_fifo_port_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) fifo_if ();

  vsm_in_fifo_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk    (clk),
    .ResetN (rst_n),
    .bus    (fifo_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic             m_oe;
  logic [WIDTH-1:0] m_bus;
  logic             m_ovf, m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_oe  = 1'b0;
    m_bus = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step(input logic load, input logic [WIDTH-1:0] d,
                            input logic rd, input logic clr);
    logic was_full, was_empty, do_pop, do_push;
    logic [WIDTH-1:0] popped;
    if (clr) begin
      model_reset();
      return;
    end
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    do_pop    = rd && !was_empty;
    do_push   = load && (!was_full || do_pop);
    popped    = '0;
    if (do_pop) popped = q.pop_front();
    if (do_push) q.push_back(d);
    if (load && !do_push) m_ovf = 1'b1;
    if (rd && was_empty)  m_udf = 1'b1;
    m_oe  = do_pop;
    m_bus = popped;
  endtask

  task automatic compare_all();
    check("oe",    32'(fifo_if.BusOe),        32'(m_oe));
    check("bus",   32'(fifo_if.BusOut),       32'(m_bus));
    check("count", 32'(fifo_if.CountOut),     32'(q.size()));
    check("full",  32'(fifo_if.FullOut),      32'(q.size() == DEPTH));
    check("empty", 32'(fifo_if.EmptyOut),     32'(q.size() == 0));
    check("ovf",   32'(fifo_if.OverflowOut),  32'(m_ovf));
    check("udf",   32'(fifo_if.UnderflowOut), 32'(m_udf));
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance, compare.
  task automatic step(input logic load, input logic [WIDTH-1:0] d,
                      input logic rd, input logic clr);
    fifo_if.LoadIn  = load;
    fifo_if.DataIn  = d;
    fifo_if.ReadEn  = rd;
    fifo_if.ClearIn = clr;
    @(posedge clk);
    model_step(load, d, rd, clr);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic reset_check();
    check("rst_oe",    32'(fifo_if.BusOe),        32'd0);
    check("rst_bus",   32'(fifo_if.BusOut),       32'd0);
    check("rst_count", 32'(fifo_if.CountOut),     32'd0);
    check("rst_empty", 32'(fifo_if.EmptyOut),     32'd1);
    check("rst_full",  32'(fifo_if.FullOut),      32'd0);
    check("rst_ovf",   32'(fifo_if.OverflowOut),  32'd0);
    check("rst_udf",   32'(fifo_if.UnderflowOut), 32'd0);
  endtask

  initial begin
    fifo_if.DataIn  = '0;
    fifo_if.LoadIn  = 1'b0;
    fifo_if.ReadEn  = 1'b0;
    fifo_if.ClearIn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 reset_check();
    rst_n = 1'b1;
    @(negedge clk);

    // Basic in-order push then pop
    for (int i = 1; i <= 3; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check("seq_bus", 32'(fifo_if.BusOut), 32'(i));
    end
    idle();
    check("seq_empty", 32'(fifo_if.EmptyOut), 32'd1);

    // Fill past capacity, then drain
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, WIDTH'(i), 1'b0, 1'b0);
      if (i == 4) check("full_at4", 32'(fifo_if.FullOut), 32'd1);
    end
    check("ovf_at5", 32'(fifo_if.OverflowOut), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check("drain_bus", 32'(fifo_if.BusOut), 32'(i));
    end

    // Underflow, then clear flags
    step(1'b0, '0, 1'b1, 1'b0);
    check("udf_oe", 32'(fifo_if.BusOe), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("clr_udf", 32'(fifo_if.UnderflowOut), 32'd0);

    // Push accepted alongside a read of an empty FIFO
    step(1'b1, 4'h7, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("udf_push_bus", 32'(fifo_if.BusOut), 32'h7);
    step(1'b0, '0, 1'b0, 1'b1);

    // Full FIFO with simultaneous push and pop
    for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    step(1'b1, 4'h9, 1'b1, 1'b0);
    check("fullrw_bus",   32'(fifo_if.BusOut),      32'd1);
    check("fullrw_count", 32'(fifo_if.CountOut),    32'd4);
    check("fullrw_ovf",   32'(fifo_if.OverflowOut), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Clear overrides push and pop in the same cycle
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 4'h4, 1'b1, 1'b1);

    // Wrap-around with interleaved push/pop pairs
    for (int i = 0; i < 10; i++) begin
      step(1'b1, WIDTH'(4'hA + i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      check("wrap_bus", 32'(fifo_if.BusOut), 32'(WIDTH'(4'hA + i)));
    end

    // Mid-operation reset discards queued words
    for (int i = 1; i <= 3; i++) step(1'b1, WIDTH'(i + 4), 1'b0, 1'b0);
    fifo_if.LoadIn = 1'b0;
    rst_n = 1'b0;
    #1 reset_check();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
    step(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_oe", 32'(fifo_if.BusOe), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), WIDTH'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
